// File: rtl/gsensor_spi_responder_if.sv
// rtl/gsensor_spi_responder_if.sv - SPI pin bundle between an initiator and the gsensor responder
interface gsensor_spi_responder_if;
  logic spi_csn;
  logic spi_sclk;
  logic spi_sdi;
  logic spi_sdo;
  logic spi_sdo_oe;
  logic spi_sdi_out;
  logic spi_sdi_oe;

  modport master (
    output spi_csn, spi_sclk, spi_sdi,
    input  spi_sdo, spi_sdo_oe, spi_sdi_out, spi_sdi_oe
  );

  modport slave (
    input  spi_csn, spi_sclk, spi_sdi,
    output spi_sdo, spi_sdo_oe, spi_sdi_out, spi_sdi_oe
  );
endinterface

// File: rtl/gsensor_spi_responder.sv
// rtl/gsensor_spi_responder.sv - mode-3 SPI register responder emulating an accelerometer
// Optional 3-wire read path enabled by defining GSENSOR_3WIRE_EN.
module gsensor_spi_responder #(
  parameter logic [7:0] DEVID       = 8'hE5,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  gsensor_spi_responder_if.slave spi,
  input  logic signed [15:0]  sample_x,
  input  logic signed [15:0]  sample_y,
  input  logic signed [15:0]  sample_z,
  input  logic                sample_valid,
  output logic                int1
);

  typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_t;
  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] csn_sync_q, sclk_sync_q, sdi_sync_q;
  logic        csn_prev_q, sclk_prev_q;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  sin_q, sin_d;
  logic [7:0]  sout_q, sout_d;
  logic [5:0]  addr_q, addr_d;
  logic        mb_q, mb_d;
  logic        sdo_q, sdo_d;
  logic [7:0]  bw_rate_q, bw_rate_d, power_ctl_q, power_ctl_d;
  logic [7:0]  int_enable_q, int_enable_d, data_format_q, data_format_d;
  logic [47:0] snap_q, snap_d;
  logic        data_ready_q, data_ready_d, int1_q, int1_d;

  logic       csn_s, sclk_s, sdi_s;
  logic       csn_fall, csn_rise, sclk_rise, sclk_fall, byte_done, rd_clear;
  logic [7:0] rx_byte, rd_data;
  logic [5:0] next_addr, rd_addr;
  logic       read_drive, sdo_oe, sdi_oe, three_wire;

  assign csn_s     = csn_sync_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign sdi_s     = sdi_sync_q[SYNC_STAGES-1];
  assign csn_fall  = csn_prev_q & ~csn_s;
  assign csn_rise  = ~csn_prev_q & csn_s;
  assign sclk_rise = ~sclk_prev_q & sclk_s & ~csn_s;
  assign sclk_fall = sclk_prev_q & ~sclk_s & ~csn_s;
  assign byte_done = sclk_rise && (state_q != IDLE) && (bit_cnt_q == 3'd7);
  assign rx_byte   = {sin_q, sdi_s};
  assign next_addr = addr_q + {5'd0, mb_q};

`ifdef GSENSOR_3WIRE_EN
  assign three_wire = data_format_q[6];
`else
  assign three_wire = 1'b0;
`endif

  // Samples are frozen when a read command lands so a burst sees one coherent X/Y/Z set.
  assign snap_d = (byte_done && state_q == CMD && rx_byte[7]) ?
                  {sample_z, sample_y, sample_x} : snap_q;

  always_comb begin
    rd_addr = (state_q == CMD) ? rx_byte[5:0] : next_addr;
    case (rd_addr)
      6'h00:   rd_data = DEVID;
      6'h2C:   rd_data = bw_rate_q;
      6'h2D:   rd_data = power_ctl_q;
      6'h2E:   rd_data = int_enable_q;
      6'h30:   rd_data = {data_ready_q, 7'd0};
      6'h31:   rd_data = data_format_q;
      6'h32:   rd_data = snap_d[7:0];
      6'h33:   rd_data = snap_d[15:8];
      6'h34:   rd_data = snap_d[23:16];
      6'h35:   rd_data = snap_d[31:24];
      6'h36:   rd_data = snap_d[39:32];
      6'h37:   rd_data = snap_d[47:40];
      default: rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (csn_rise) begin
      state_d = IDLE;
    end else if (csn_fall) begin
      state_d = CMD;
    end else if (byte_done && state_q == CMD) begin
      state_d = rx_byte[7] ? RDATA : WDATA;
    end
  end

  always_comb begin
    read_drive = (state_q == RDATA) && !csn_s;
    sdo_oe     = read_drive & ~three_wire;
    sdi_oe     = read_drive & three_wire;
  end

  always_comb begin
    bit_cnt_d     = bit_cnt_q;
    sin_d         = sin_q;
    sout_d        = sout_q;
    addr_d        = addr_q;
    mb_d          = mb_q;
    sdo_d         = sdo_q;
    bw_rate_d     = bw_rate_q;
    power_ctl_d   = power_ctl_q;
    int_enable_d  = int_enable_q;
    data_format_d = data_format_q;
    data_ready_d  = data_ready_q;
    rd_clear      = 1'b0;
    if (csn_fall || csn_rise) begin
      bit_cnt_d = 3'd0;
      sin_d     = 7'd0;
      sout_d    = 8'd0;
      sdo_d     = 1'b0;
    end else if (state_q != IDLE) begin
      if (sclk_rise) begin
        sin_d     = rx_byte[6:0];
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (byte_done) begin
          case (state_q)
            CMD: begin
              mb_d   = rx_byte[6];
              addr_d = rx_byte[5:0];
              sout_d = rd_data;
            end
            WDATA: begin
              case (addr_q)
                6'h2C:   bw_rate_d     = rx_byte;
                6'h2D:   power_ctl_d   = rx_byte;
                6'h2E:   int_enable_d  = rx_byte;
                6'h31:   data_format_d = rx_byte;
                default: ;
              endcase
              addr_d = next_addr;
            end
            RDATA: begin
              rd_clear = (addr_q >= 6'h32) && (addr_q <= 6'h37);
              addr_d   = next_addr;
              sout_d   = rd_data;
            end
            default: ;
          endcase
        end
      end else if (sclk_fall && state_q == RDATA) begin
        sdo_d  = sout_q[7];
        sout_d = {sout_q[6:0], 1'b0};
      end
    end
    // A new sample arriving in the same cycle as a data read keeps the flag set.
    if (rd_clear) data_ready_d = 1'b0;
    if (sample_valid && power_ctl_q[3]) data_ready_d = 1'b1;
    int1_d = int_enable_q[7] & data_ready_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      csn_sync_q    <= '1;
      sclk_sync_q   <= '1;
      sdi_sync_q    <= '0;
      csn_prev_q    <= 1'b1;
      sclk_prev_q   <= 1'b1;
      bit_cnt_q     <= 3'd0;
      sin_q         <= 7'd0;
      sout_q        <= 8'd0;
      addr_q        <= 6'd0;
      mb_q          <= 1'b0;
      sdo_q         <= 1'b0;
      bw_rate_q     <= 8'h0A;
      power_ctl_q   <= 8'h00;
      int_enable_q  <= 8'h00;
      data_format_q <= 8'h00;
      snap_q        <= 48'd0;
      data_ready_q  <= 1'b0;
      int1_q        <= 1'b0;
    end else begin
      csn_sync_q    <= {csn_sync_q[SYNC_STAGES-2:0], spi.spi_csn};
      sclk_sync_q   <= {sclk_sync_q[SYNC_STAGES-2:0], spi.spi_sclk};
      sdi_sync_q    <= {sdi_sync_q[SYNC_STAGES-2:0], spi.spi_sdi};
      csn_prev_q    <= csn_s;
      sclk_prev_q   <= sclk_s;
      bit_cnt_q     <= bit_cnt_d;
      sin_q         <= sin_d;
      sout_q        <= sout_d;
      addr_q        <= addr_d;
      mb_q          <= mb_d;
      sdo_q         <= sdo_d;
      bw_rate_q     <= bw_rate_d;
      power_ctl_q   <= power_ctl_d;
      int_enable_q  <= int_enable_d;
      data_format_q <= data_format_d;
      snap_q        <= snap_d;
      data_ready_q  <= data_ready_d;
      int1_q        <= int1_d;
    end
  end

  assign spi.spi_sdo     = sdo_q & sdo_oe;
  assign spi.spi_sdo_oe  = sdo_oe;
  assign spi.spi_sdi_out = sdo_q & sdi_oe;
  assign spi.spi_sdi_oe  = sdi_oe;
  assign int1            = int1_q;

endmodule

// File: tb/tb_gsensor_spi_responder.sv
// tb/tb_gsensor_spi_responder.sv - scoreboard bench for gsensor_spi_responder
module tb_gsensor_spi_responder;
  logic clk = 1'b0;
  logic reset_n;
  logic signed [15:0] sample_x, sample_y, sample_z;
  logic sample_valid;
  logic int1;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_acc;
  logic [7:0] mon_exp;
  int   mon_bits;

  gsensor_spi_responder_if bus();

  gsensor_spi_responder dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .spi          (bus),
    .sample_x     (sample_x),
    .sample_y     (sample_y),
    .sample_z     (sample_z),
    .sample_valid (sample_valid),
    .int1         (int1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic spi_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      bus.spi_sclk = 1'b0;
      bus.spi_sdi  = b[i];
      repeat (8) @(negedge clk);
      bus.spi_sclk = 1'b1;
      repeat (8) @(negedge clk);
    end
  endtask

  task automatic spi_start();
    bus.spi_csn = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic spi_end();
    bus.spi_csn = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic spi_write(input logic [7:0] cmd, input logic [7:0] data);
    spi_start();
    spi_bits(cmd, 8);
    spi_bits(data, 8);
    spi_end();
  endtask

  task automatic pulse_sample();
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  // Monitor: assembles bytes from whichever read line is enabled and scores them.
  initial begin
    mon_bits = 0;
    mon_acc  = 8'd0;
    forever begin
      @(posedge bus.spi_sclk or posedge bus.spi_csn);
      if (bus.spi_csn) begin
        mon_bits = 0;
      end else if (bus.spi_sdo_oe || bus.spi_sdi_oe) begin
        mon_acc = {mon_acc[6:0], bus.spi_sdo_oe ? bus.spi_sdo : bus.spi_sdi_out};
        mon_bits++;
        if (mon_bits == 8) begin
          mon_bits = 0;
          if (exp_q.size() == 0) begin
            check("unexpected_read_byte", {24'd0, mon_acc}, 32'hFFFF_FFFF);
          end else begin
            mon_exp = exp_q.pop_front();
            check("read_byte", {24'd0, mon_acc}, {24'd0, mon_exp});
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n      = 1'b0;
    bus.spi_csn  = 1'b1;
    bus.spi_sclk = 1'b1;
    bus.spi_sdi  = 1'b0;
    sample_x     = 16'h0123;
    sample_y     = 16'hFF80;
    sample_z     = 16'h0100;
    sample_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_sdo", {31'd0, bus.spi_sdo}, 0);
    check("rst_sdo_oe", {31'd0, bus.spi_sdo_oe}, 0);
    check("rst_sdi_out", {31'd0, bus.spi_sdi_out}, 0);
    check("rst_sdi_oe", {31'd0, bus.spi_sdi_oe}, 0);
    check("rst_int1", {31'd0, int1}, 0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // DEVID read, 4-wire drive enable during and after the transfer
    exp_q.push_back(8'hE5);
    spi_start();
    spi_bits(8'h80, 8);
    check("devid_sdo_oe_active", {31'd0, bus.spi_sdo_oe}, 1);
    spi_bits(8'h00, 8);
    spi_end();
    check("devid_sdo_oe_after", {31'd0, bus.spi_sdo_oe}, 0);

    // POWER_CTL write / readback, BW_RATE reset value
    spi_write(8'h2D, 8'h08);
    exp_q.push_back(8'h08);
    spi_start(); spi_bits(8'hAD, 8); spi_bits(8'h00, 8); spi_end();
    exp_q.push_back(8'h0A);
    spi_start(); spi_bits(8'hAC, 8); spi_bits(8'h00, 8); spi_end();

    // Aborted write leaves INT_ENABLE untouched
    spi_start(); spi_bits(8'h2E, 8); spi_bits(8'hFF, 5); spi_end();
    exp_q.push_back(8'h00);
    spi_start(); spi_bits(8'hAE, 8); spi_bits(8'h00, 8); spi_end();

    // Burst from Z0 runs into unmapped 0x38; burst from 0x3F wraps to DEVID
    exp_q.push_back(8'h00); exp_q.push_back(8'h01); exp_q.push_back(8'h00);
    spi_start(); spi_bits(8'hF6, 8);
    for (int i = 0; i < 3; i++) spi_bits(8'h00, 8);
    spi_end();
    exp_q.push_back(8'h00); exp_q.push_back(8'hE5);
    spi_start(); spi_bits(8'hFF, 8);
    for (int i = 0; i < 2; i++) spi_bits(8'h00, 8);
    spi_end();

    // Data-ready interrupt and six-byte sample burst
    spi_write(8'h2E, 8'h80);
    pulse_sample();
    @(negedge clk);
    check("int1_set", {31'd0, int1}, 1);
    exp_q.push_back(8'h23); exp_q.push_back(8'h01); exp_q.push_back(8'h80);
    exp_q.push_back(8'hFF); exp_q.push_back(8'h00); exp_q.push_back(8'h01);
    spi_start(); spi_bits(8'hF2, 8);
    spi_bits(8'h00, 8);
    check("int1_clear_after_x0", {31'd0, int1}, 0);
    for (int i = 0; i < 5; i++) spi_bits(8'h00, 8);
    spi_end();

    // sample_valid ignored while POWER_CTL[3]=0
    spi_write(8'h2D, 8'h00);
    pulse_sample();
    repeat (4) @(negedge clk);
    check("int1_measure_off", {31'd0, int1}, 0);
    exp_q.push_back(8'h00);
    spi_start(); spi_bits(8'hB0, 8); spi_bits(8'h00, 8); spi_end();

    // Set coincident with a Z1 read completion keeps data_ready
    spi_write(8'h2D, 8'h08);
    pulse_sample();
    repeat (4) @(negedge clk);
    check("int1_rearmed", {31'd0, int1}, 1);
    exp_q.push_back(8'h01);
    spi_start(); spi_bits(8'hB7, 8);
    spi_bits(8'h00, 7);
    bus.spi_sclk = 1'b0;
    bus.spi_sdi  = 1'b0;
    repeat (8) @(negedge clk);
    bus.spi_sclk = 1'b1;
    @(negedge clk);
    sample_valid = 1'b1;
    repeat (2) @(negedge clk);
    sample_valid = 1'b0;
    repeat (5) @(negedge clk);
    spi_end();
    check("int1_set_wins", {31'd0, int1}, 1);
    exp_q.push_back(8'h80);
    spi_start(); spi_bits(8'hB0, 8); spi_bits(8'h00, 8); spi_end();

    // Reset in the middle of a write, then a fresh transaction
    spi_start(); spi_bits(8'h2C, 8); spi_bits(8'h55, 4);
    reset_n      = 1'b0;
    bus.spi_csn  = 1'b1;
    bus.spi_sclk = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_sdo_oe", {31'd0, bus.spi_sdo_oe}, 0);
    check("midrst_int1", {31'd0, int1}, 0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    exp_q.push_back(8'h0A);
    spi_start(); spi_bits(8'hAC, 8); spi_bits(8'h00, 8); spi_end();

`ifdef GSENSOR_3WIRE_EN
    spi_write(8'h31, 8'h40);
    exp_q.push_back(8'hE5);
    spi_start(); spi_bits(8'h80, 8);
    check("3w_sdi_oe", {31'd0, bus.spi_sdi_oe}, 1);
    check("3w_sdo_oe", {31'd0, bus.spi_sdo_oe}, 0);
    spi_bits(8'h00, 8);
    spi_end();
    check("3w_sdi_oe_after", {31'd0, bus.spi_sdi_oe}, 0);
`endif

    repeat (4) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
